// File: rtl/disp_arbiter.sv
// Round-robin arbiter handing a shared 4-digit display to one of three requesters for at least DWELL cycles.
// All outputs registered, 1-cycle latency from req; no backpressure, requesters hold req as a level until served.
module disp_arbiter #(
  parameter int unsigned DWELL = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [47:0] req_value,
  output logic [2:0]  grant,
  output logic [15:0] disp_value,
  output logic        disp_blank
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam logic [15:0] LP_RELOAD = 16'(DWELL - 1);

  state_t      r_state;
  logic [1:0]  r_last;
  logic [15:0] r_cnt;
  logic [2:0]  r_grant;
  logic [15:0] r_disp_value;
  logic        r_disp_blank;

  logic [1:0]  w_c0;
  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic        w_idle_hit;
  logic [1:0]  w_idle_win;
  logic        w_sw_hit;
  logic [1:0]  w_sw_win;
  logic        w_own_req;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic bit_of(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  function automatic logic [15:0] val_of(input logic [47:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[15:0];
      2'd1:    return v[31:16];
      default: return v[47:32];
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Search order is last+1, last+2, last. While owning, r_last is the owner,
  // so the first two candidates are exactly the "other" requesters.
  always_comb begin
    w_c0 = inc3(r_last);
    w_c1 = inc3(w_c0);
    w_c2 = inc3(w_c1);

    w_idle_hit = |req;
    if (bit_of(req, w_c0))
      w_idle_win = w_c0;
    else if (bit_of(req, w_c1))
      w_idle_win = w_c1;
    else
      w_idle_win = w_c2;

    w_sw_hit = bit_of(req, w_c0) | bit_of(req, w_c1);
    w_sw_win = bit_of(req, w_c0) ? w_c0 : w_c1;

    w_own_req = |(req & r_grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= 2'd2;
      r_cnt        <= 16'd0;
      r_grant      <= 3'b000;
      r_disp_value <= 16'h0000;
      r_disp_blank <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit) begin
            r_state      <= S_OWN;
            r_last       <= w_idle_win;
            r_cnt        <= LP_RELOAD;
            r_grant      <= onehot(w_idle_win);
            r_disp_value <= val_of(req_value, w_idle_win);
            r_disp_blank <= 1'b0;
          end else begin
            r_grant      <= 3'b000;
            r_disp_blank <= 1'b1;
          end
        end
        S_OWN: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
            if (w_own_req)
              r_disp_value <= val_of(req_value, r_last);
          end else if (w_sw_hit) begin
            r_last       <= w_sw_win;
            r_cnt        <= LP_RELOAD;
            r_grant      <= onehot(w_sw_win);
            r_disp_value <= val_of(req_value, w_sw_win);
            r_disp_blank <= 1'b0;
          end else if (w_own_req) begin
            // Dwell expired but uncontested: keep ownership with counter parked at 0.
            r_disp_value <= val_of(req_value, r_last);
          end else begin
            r_state      <= S_IDLE;
            r_grant      <= 3'b000;
            r_disp_blank <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_grant      <= 3'b000;
          r_disp_blank <= 1'b1;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign disp_value = r_disp_value;
  assign disp_blank = r_disp_blank;

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter with DWELL=4: vector table via scoreboard, reset corner, random traffic monitor.
module tb_disp_arbiter;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [47:0] req_value = 48'h0;
  logic [2:0]  grant;
  logic [15:0] disp_value;
  logic        disp_blank;

  int total = 0;
  int bad = 0;

  disp_arbiter #(.DWELL(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_value(req_value),
    .grant(grant),
    .disp_value(disp_value),
    .disp_blank(disp_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [15:0] v0;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [2:0]  g;
    logic [15:0] dv;
    logic        bl;
  } vec_t;

  typedef struct {
    int          id;
    logic [2:0]  g;
    logic [15:0] dv;
    logic        bl;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] r, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                              logic [2:0] g, logic [15:0] dv, logic bl);
    vec_t v;
    v.req = r; v.v0 = a; v.v1 = b; v.v2 = c; v.g = g; v.dv = dv; v.bl = bl;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, id, got, want);
    end
  endtask

  task automatic step(input vec_t v, input int id);
    exp_t e;
    req = v.req;
    req_value = {v.v2, v.v1, v.v0};
    e.id = id; e.g = v.g; e.dv = v.dv; e.bl = v.bl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty[%0d] got=0 want=1", id);
    end else begin
      e = sb.pop_front();
      chk("grant", e.id, 16'(grant), 16'(e.g));
      chk("value", e.id, disp_value, e.dv);
      chk("blank", e.id, 16'(disp_blank), 16'(e.bl));
    end
  endtask

  // Invariant monitor: one-hot-or-zero, blank tracks idle, and an owner keeps grant >= DW cycles.
  logic [2:0] m_prev = 3'b000;
  int         m_age = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev = 3'b000;
      m_age  = 0;
    end else begin
      total++;
      if (!$onehot0(grant)) begin
        bad++;
        $display("FAIL onehot got=%b want=onehot0", grant);
      end
      total++;
      if (disp_blank !== (grant == 3'b000)) begin
        bad++;
        $display("FAIL blank_inv got=%b want=%b", disp_blank, (grant == 3'b000));
      end
      if (grant !== m_prev) begin
        if (m_prev != 3'b000) begin
          total++;
          if (m_age < DW) begin
            bad++;
            $display("FAIL dwell got=%0d want>=%0d", m_age, DW);
          end
        end
        m_prev = grant;
        m_age  = 1;
      end else begin
        m_age++;
      end
    end
  end

  initial begin
    // Round-robin rotation with all three requesting.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 16'h1111, 1'b0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b010, 16'h2222, 1'b0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b100, 16'h3333, 1'b0));
    tbl.push_back(mk(3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b001, 16'h1111, 1'b0));
    // Lone owner 0 tracks its value and keeps grant past dwell.
    tbl.push_back(mk(3'b001, 16'h00AA, 16'h2222, 16'h3333, 3'b001, 16'h00AA, 1'b0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(3'b001, 16'h00BB, 16'h2222, 16'h3333, 3'b001, 16'h00BB, 1'b0));
    // Owner 1 drops early: frozen until expiry, then idle with value held.
    tbl.push_back(mk(3'b010, 16'h00BB, 16'h5555, 16'h3333, 3'b010, 16'h5555, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(3'b000, 16'h00BB, 16'h6666, 16'h3333, 3'b010, 16'h5555, 1'b0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(3'b000, 16'h00BB, 16'h6666, 16'h3333, 3'b000, 16'h5555, 1'b1));
    // Owner 2 parked at counter 0; a new request switches on its first edge.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(3'b100, 16'h00BB, 16'h6666, 16'h7777, 3'b100, 16'h7777, 1'b0));
    tbl.push_back(mk(3'b101, 16'h8888, 16'h6666, 16'h7777, 3'b001, 16'h8888, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(3'b100, 16'h8888, 16'h6666, 16'h9999, 3'b001, 16'h8888, 1'b0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(3'b100, 16'h8888, 16'h6666, 16'h9999, 3'b100, 16'h9999, 1'b0));

    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", 0, 16'(grant), 16'h0000);
    chk("rst_value", 0, disp_value, 16'h0000);
    chk("rst_blank", 0, 16'(disp_blank), 16'h0001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i + 1);

    // Asynchronous reset while grant=100 mid-dwell, then re-arbitrate from scratch.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 100, 16'(grant), 16'h0000);
    chk("mid_rst_value", 100, disp_value, 16'h0000);
    chk("mid_rst_blank", 100, 16'(disp_blank), 16'h0001);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(3'b101, 16'hAAAA, 16'h1234, 16'hBBBB, 3'b001, 16'hAAAA, 1'b0), 101);
    step(mk(3'b101, 16'hAAAC, 16'h1234, 16'hBBBB, 3'b001, 16'hAAAC, 1'b0), 102);

    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      req = 3'($urandom_range(0, 7));
      req_value = {16'($urandom()), 16'($urandom()), 16'($urandom())};
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The module SHALL have parameter DWELL, default 50000: minimum clk cycles a granted requester owns the display (legal range 1..65535).
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port req, input, 3: per-requester level request; bit i high means requester i wants the display.
REQ-005 Port req_value, input, 48: requester i's 16-bit value at bits [16*i+15:16*i].
REQ-006 Port grant, output, 3: registered one-hot owner indication; all-zero when idle.
REQ-007 Port disp_value, output, 16: registered value for the 4-digit display driver.
REQ-008 Port disp_blank, output, 1: registered; 1 when no owner (display driver blanks all digits).

Function
REQ-009 The FSM SHALL have two states: IDLE (grant=0) and OWN (grant one-hot).
REQ-010 The arbiter SHALL keep a 2-bit last-owner register, updated on every new grant; round-robin search starts at last+1 mod 3, wrapping 2->0.
REQ-011 IDLE: if req!=0 at edge N, the winner SHALL be selected by round-robin; at edge N: grant=winner, state=OWN, disp_blank=0, disp_value=winner's req_value, dwell counter=DWELL-1.
REQ-012 IDLE with req=0 SHALL hold grant=0, disp_blank=1, and disp_value unchanged.
REQ-013 OWN: the dwell counter SHALL decrement by 1 per cycle while nonzero and saturate at 0 (no wrap).
REQ-014 OWN: while the owner's req bit is high, disp_value SHALL load the owner's req_value every cycle (1-cycle latency); while it is low, disp_value SHALL freeze.
REQ-015 OWN with counter!=0: grant SHALL NOT change, regardless of req; an owner dropping req early still holds the display until dwell expiry.
REQ-016 OWN with counter=0 and another requester asserting: the arbiter SHALL switch at that edge to the next requester in round-robin order excluding the current owner, reload counter=DWELL-1, and load that requester's value.
REQ-017 OWN with counter=0, only the owner requesting: the arbiter SHALL retain grant with counter held at 0, so a later competing request switches on its first cycle.
REQ-018 OWN with counter=0 and req=0: the arbiter SHALL go to IDLE at that edge with grant=0 and disp_blank=1; disp_value holds its last value.
REQ-019 DWELL=1: the counter SHALL load 0, so ownership lasts a minimum of one cycle.
REQ-020 grant SHALL never have more than one bit set, and disp_blank SHALL equal (grant==0) on every cycle.
REQ-021 Undefined or unused req bits SHALL not exist (all 3 are valid); X on req SHALL not be required to be handled.

Reset
REQ-022 While rst_n=0, the module SHALL immediately (asynchronously) force grant=0, disp_value=0x0000, disp_blank=1, state=IDLE, counter=0, last-owner=2 (so requester 0 has highest priority after reset).
REQ-023 Reset asserted mid-ownership SHALL abort it; after release the arbiter SHALL re-arbitrate from IDLE with no memory of the prior owner.
REQ-024 The first edge after rst_n rises SHALL already arbitrate normally.

Verification (DWELL=4)
REQ-025 After reset, req=3'b111 and values 0x1111/0x2222/0x3333 -> next edge grant=001, disp_value=0x1111; after 4 cycles grant=010, 0x2222; after 4 more grant=100, 0x3333; then wrap to 001.
REQ-026 Owner 0 alone, req_value0 changes 0x00AA->0x00BB -> disp_value shows 0x00BB one cycle later; grant stays 001 indefinitely.
REQ-027 Owner 1 drops req 1 cycle after grant, no others -> grant stays 010 and disp_value frozen until dwell expiry, then grant=000 and disp_blank=1 with disp_value unchanged.
REQ-028 Owner 2 held past dwell (counter=0), req0 rises -> grant=001 on the very next edge.
REQ-029 rst_n pulsed low mid-dwell while grant=100 -> outputs go to 000/0x0000/1 without waiting for a clock edge; after release, with req=3'b101, grant=001 first.
REQ-030 Throughout random req traffic, a bench assertion SHALL check that grant is one-hot-or-zero, disp_blank==(grant==0), and no grant change occurs earlier than DWELL cycles after the previous change.
